// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: computes the branch target, detects branch-operand
// hazards against EX/MEM producers, and keeps taken/stall statistics.
module branch_resolve_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_branch,
  input  logic             id_bne,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             equal,
  input  logic [31:0]      id_pc_plus4,
  input  logic [31:0]      id_imm,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  output logic             stall,
  output logic             pc_src,
  output logic             if_flush,
  output logic [31:0]      branch_target,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_br, w_cond, w_ex_haz, w_mem_haz, w_hazard;
  logic w_stall, w_pc_src;

  assign w_br      = id_branch | id_bne;
  assign w_cond    = (id_branch & equal) | (id_bne & ~equal);
  assign w_ex_haz  = ex_regwrite & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign w_mem_haz = mem_memread & (mem_rd != 5'd0) & ((mem_rd == id_rs) | (mem_rd == id_rt));
  assign w_hazard  = w_br & (w_ex_haz | w_mem_haz);

  assign branch_target = id_pc_plus4 + {id_imm[29:0], 2'b00};

  // Reset gates the outputs directly so they drop without waiting for a clock.
  always_comb begin
    w_stall  = 1'b0;
    w_pc_src = 1'b0;
    if (!reset) begin
      if (r_state == HOLD) begin
        w_stall = 1'b1;
      end else if (w_hazard) begin
        w_stall = 1'b1;
      end else begin
        w_pc_src = w_br & w_cond;
      end
    end
  end

  assign stall     = w_stall;
  assign pc_src    = w_pc_src;
  assign if_flush  = w_pc_src;
  assign taken_cnt = r_taken_cnt;
  assign stall_cnt = r_stall_cnt;

  // A load in EX needs one extra cycle beyond the first stall; EX rule wins over MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    r_state <= (w_hazard && w_ex_haz && ex_memread) ? HOLD : IDLE;
        HOLD:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pc_src && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      if (w_stall && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule
